// File: rtl/jacobi_1d_invoker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : jacobi_invoke_pkg                                          |
// | Brief   : Shared types and defaults for the jacobi_1d call invoker.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package jacobi_invoke_pkg;

  localparam int C_ADDR_W  = 64;
  localparam int C_STEP_W  = 16;
  localparam int C_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [C_ADDR_W-1:0] a1;
    logic [C_ADDR_W-1:0] a2;
    logic [C_ADDR_W-1:0] b;
    logic [C_STEP_W-1:0] steps;
  } job_t;

  typedef struct packed {
    logic [C_STEP_W-1:0] steps;
    logic                timeout;
    logic [C_ADDR_W-1:0] last_b;
  } resp_t;

  // Odd-numbered calls run with A_1 and B exchanged.
  function automatic logic call_is_swapped(input logic call_idx_lsb);
    return call_idx_lsb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jacobi_1d_invoker_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : jacobi_1d_invoker_if                                     |
// | Brief     : Job, response and component call/return signals.        |
// |             master = invoker side, slave = host + component side.    |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface jacobi_1d_invoker_if
  import jacobi_invoke_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int STEP_W = C_STEP_W
) ();

  // job request
  logic              job_valid;
  logic              job_ready;
  logic [ADDR_W-1:0] job_a1;
  logic [ADDR_W-1:0] job_a2;
  logic [ADDR_W-1:0] job_b;
  logic [STEP_W-1:0] job_steps;

  // job response
  logic              resp_valid;
  logic              resp_ready;
  logic [STEP_W-1:0] resp_steps;
  logic              resp_timeout;
  logic [ADDR_W-1:0] resp_last_b;

  // component call / return
  logic              comp_start;
  logic              comp_busy;
  logic [ADDR_W-1:0] comp_a_1;
  logic [ADDR_W-1:0] comp_a_2;
  logic [ADDR_W-1:0] comp_b;
  logic              comp_done;
  logic              comp_stall;

  modport master (
    input  job_valid, job_a1, job_a2, job_b, job_steps,
    output job_ready,
    output resp_valid, resp_steps, resp_timeout, resp_last_b,
    input  resp_ready,
    output comp_start, comp_a_1, comp_a_2, comp_b, comp_stall,
    input  comp_busy, comp_done
  );

  modport slave (
    output job_valid, job_a1, job_a2, job_b, job_steps,
    input  job_ready,
    input  resp_valid, resp_steps, resp_timeout, resp_last_b,
    output resp_ready,
    input  comp_start, comp_a_1, comp_a_2, comp_b, comp_stall,
    output comp_busy, comp_done
  );

endinterface
`default_nettype wire

// File: rtl/jacobi_1d_invoker_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : hls_call_watchdog                                           |
// | Brief  : Counts enabled cycles since clear; flags the TIMEOUT-th     |
// |          enabled cycle. TIMEOUT == 0 disables the watchdog.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module hls_call_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_expired
);

  generate
    if (TIMEOUT == 0) begin : g_disabled
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst, i_clear, i_enable};
      assign o_expired = 1'b0;
    end else begin : g_enabled
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] r_cnt;

      // First enabled cycle sees count 0, so count TIMEOUT-1 marks the TIMEOUT-th cycle.
      always_ff @(posedge clk) begin
        if (rst || i_clear) begin
          r_cnt <= '0;
        end else if (i_enable && (r_cnt != C_LAST)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_expired = i_enable && (r_cnt == C_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/jacobi_1d_invoker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : jacobi_1d_invoker                                           |
// | Brief  : Caller-side driver for the jacobi_1d HLS component. Runs a  |
// |          job as a sequence of component calls, ping-ponging A_1/B,   |
// |          and reports completion or watchdog timeout.                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module jacobi_1d_invoker
  import jacobi_invoke_pkg::*;
#(
  parameter int ADDR_W  = C_ADDR_W,
  parameter int STEP_W  = C_STEP_W,
  parameter int TIMEOUT = C_TIMEOUT
) (
  input  wire logic            clk,
  input  wire logic            rst,
  jacobi_1d_invoker_if.master  bus,
  output logic [7:0]           stray_cnt
);

  state_t            r_state;

  // latched job
  logic [ADDR_W-1:0] r_a1;
  logic [ADDR_W-1:0] r_b;
  logic [STEP_W-1:0] r_steps;
  logic [STEP_W-1:0] r_step_cnt;
  logic [ADDR_W-1:0] r_last_b;

  // registered outputs
  logic              r_job_ready;
  logic              r_comp_start;
  logic              r_comp_stall;
  logic [ADDR_W-1:0] r_arg_a1;
  logic [ADDR_W-1:0] r_arg_a2;
  logic [ADDR_W-1:0] r_arg_b;
  logic              r_resp_valid;
  logic [STEP_W-1:0] r_resp_steps;
  logic              r_resp_timeout;
  logic [ADDR_W-1:0] r_resp_last_b;
  logic [7:0]        r_stray_cnt;

  logic [STEP_W-1:0] w_step_next;
  logic              w_wd_clear;
  logic              w_wd_enable;
  logic              w_wd_expired;

  assign w_step_next = r_step_cnt + STEP_W'(1);
  assign w_wd_enable = (r_state == WAIT);
  assign w_wd_clear  = (r_state != WAIT);

  hls_call_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  // Job sequencing FSM: accept job, issue calls, await returns, present response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_a1           <= '0;
      r_b            <= '0;
      r_steps        <= '0;
      r_step_cnt     <= '0;
      r_last_b       <= '0;
      r_job_ready    <= 1'b1;
      r_comp_start   <= 1'b0;
      r_comp_stall   <= 1'b0;
      r_arg_a1       <= '0;
      r_arg_a2       <= '0;
      r_arg_b        <= '0;
      r_resp_valid   <= 1'b0;
      r_resp_steps   <= '0;
      r_resp_timeout <= 1'b0;
      r_resp_last_b  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.job_valid) begin
            r_a1        <= bus.job_a1;
            r_b         <= bus.job_b;
            r_steps     <= bus.job_steps;
            r_step_cnt  <= '0;
            r_last_b    <= bus.job_a1;
            r_arg_a1    <= bus.job_a1;
            r_arg_a2    <= bus.job_a2;
            r_arg_b     <= bus.job_b;
            r_job_ready <= 1'b0;
            if (bus.job_steps == '0) begin
              // Nothing to run: input buffer A_1 already holds the result.
              r_state        <= RESP;
              r_resp_valid   <= 1'b1;
              r_resp_steps   <= '0;
              r_resp_timeout <= 1'b0;
              r_resp_last_b  <= bus.job_a1;
              r_comp_stall   <= 1'b1;
            end else begin
              r_state      <= ISSUE;
              r_comp_start <= 1'b1;
              r_comp_stall <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (!bus.comp_busy) begin
            r_state      <= WAIT;
            r_comp_start <= 1'b0;
            r_comp_stall <= 1'b0;
          end
        end

        WAIT: begin
          if (bus.comp_done) begin
            // A done on the watchdog expiry cycle still counts as completion.
            r_step_cnt <= w_step_next;
            r_last_b   <= r_arg_b;
            if (w_step_next == r_steps) begin
              r_state        <= RESP;
              r_resp_valid   <= 1'b1;
              r_resp_steps   <= w_step_next;
              r_resp_timeout <= 1'b0;
              r_resp_last_b  <= r_arg_b;
              r_comp_stall   <= 1'b1;
            end else begin
              r_state      <= ISSUE;
              r_comp_start <= 1'b1;
              r_comp_stall <= 1'b1;
              if (call_is_swapped(w_step_next[0])) begin
                r_arg_a1 <= r_b;
                r_arg_b  <= r_a1;
              end else begin
                r_arg_a1 <= r_a1;
                r_arg_b  <= r_b;
              end
            end
          end else if (w_wd_expired) begin
            r_state        <= RESP;
            r_resp_valid   <= 1'b1;
            r_resp_steps   <= r_step_cnt;
            r_resp_timeout <= 1'b1;
            r_resp_last_b  <= r_last_b;
            r_comp_stall   <= 1'b1;
          end
        end

        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_job_ready  <= 1'b1;
            r_comp_stall <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Count returns arriving while no call is outstanding, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stray_cnt <= '0;
    end else if ((r_state == IDLE) && bus.comp_done && (r_stray_cnt != 8'hFF)) begin
      r_stray_cnt <= r_stray_cnt + 8'd1;
    end
  end

  assign bus.job_ready    = r_job_ready;
  assign bus.comp_start   = r_comp_start;
  assign bus.comp_stall   = r_comp_stall;
  assign bus.comp_a_1     = r_arg_a1;
  assign bus.comp_a_2     = r_arg_a2;
  assign bus.comp_b       = r_arg_b;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_steps   = r_resp_steps;
  assign bus.resp_timeout = r_resp_timeout;
  assign bus.resp_last_b  = r_resp_last_b;
  assign stray_cnt        = r_stray_cnt;

endmodule
`default_nettype wire

// File: tb/tb_jacobi_1d_invoker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_jacobi_1d_invoker                                        |
// | Brief  : Scoreboard bench for jacobi_1d_invoker with a behavioural   |
// |          component model (configurable busy, return delay, drop).    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_jacobi_1d_invoker;
  import jacobi_invoke_pkg::*;

  typedef struct {
    logic [63:0] a1;
    logic [63:0] a2;
    logic [63:0] b;
  } call_t;

  typedef struct {
    resp_t r;
    int    lat;
  } rexp_t;

  logic       clk;
  logic       rst;
  logic [7:0] stray_cnt;

  jacobi_1d_invoker_if #(.ADDR_W(64), .STEP_W(16)) bus ();

  jacobi_1d_invoker #(
    .ADDR_W  (64),
    .STEP_W  (16),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .stray_cnt (stray_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ref_cyc = 0;
  int n_resp = 0;

  call_t exp_calls[$];
  rexp_t exp_resps[$];

  // component model knobs
  int m_busy      = 0;
  int m_delay     = 1;
  int m_drop_from = 1000;
  int m_call_idx  = 0;
  int issue_len   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_call(input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] b);
    call_t c;
    c.a1 = a1; c.a2 = a2; c.b = b;
    exp_calls.push_back(c);
  endfunction

  // Calls 0..n-1 of a job following the A_1/B ping-pong rule.
  function automatic void push_calls(input logic [63:0] a1, input logic [63:0] a2,
                                     input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 2 == 1) push_call(b, a2, a1);
      else            push_call(a1, a2, b);
    end
  endfunction

  function automatic void push_resp(input logic [15:0] steps, input logic tmo,
                                    input logic [63:0] last_b, input int lat);
    rexp_t e;
    e.r.steps = steps; e.r.timeout = tmo; e.r.last_b = last_b; e.lat = lat;
    exp_resps.push_back(e);
  endfunction

  // Component model: checks presented arguments, handles busy and return delay.
  initial begin : comp_model
    int hold;
    int idx;
    hold = 0;
    forever begin
      @(negedge clk);
      if (bus.comp_start && !rst) begin
        chk("issue_stall", bus.comp_stall, 1'b1);
        if (exp_calls.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_call: got comp_start=1 expected no call (cycle %0d)", cyc);
        end else begin
          chk("call_a1", bus.comp_a_1, exp_calls[0].a1);
          chk("call_a2", bus.comp_a_2, exp_calls[0].a2);
          chk("call_b",  bus.comp_b,   exp_calls[0].b);
        end
        if (bus.comp_busy) begin
          hold++;
          if (hold >= m_busy) begin
            @(posedge clk);
            #1 bus.comp_busy = 1'b0;
          end
        end else begin
          issue_len = hold + 1;
          hold = 0;
          if (exp_calls.size() > 0) void'(exp_calls.pop_front());
          ref_cyc = cyc;
          idx = m_call_idx;
          m_call_idx++;
          @(posedge clk);
          #1 bus.comp_busy = (m_busy > 0);
          if (idx < m_drop_from) begin
            for (int i = 1; i < m_delay; i++) begin
              @(posedge clk);
              #1;
            end
            bus.comp_done = 1'b1;
            @(posedge clk);
            #1 bus.comp_done = 1'b0;
          end
        end
      end
    end
  end

  // Response monitor: compares each presented response against the scoreboard.
  initial begin : resp_mon
    bit seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (bus.resp_valid) begin
        if (exp_resps.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          if (!seen) chk("resp_latency", 64'(cyc - ref_cyc), 64'(exp_resps[0].lat));
          chk("resp_steps",   bus.resp_steps,   exp_resps[0].r.steps);
          chk("resp_timeout", bus.resp_timeout, exp_resps[0].r.timeout);
          chk("resp_last_b",  bus.resp_last_b,  exp_resps[0].r.last_b);
          chk("resp_job_ready", bus.job_ready,  1'b0);
          chk("resp_stall",   bus.comp_stall,   1'b1);
          seen = 1'b1;
          if (bus.resp_ready) begin
            void'(exp_resps.pop_front());
            n_resp++;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_job(input logic [63:0] a1, input logic [63:0] a2,
                          input logic [63:0] b, input logic [15:0] steps);
    int n;
    n = 0;
    m_call_idx    = 0;
    bus.job_a1    = a1;
    bus.job_a2    = a2;
    bus.job_b     = b;
    bus.job_steps = steps;
    bus.job_valid = 1'b1;
    @(negedge clk);
    while (!bus.job_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("job_accept", bus.job_ready, 1'b1);
    ref_cyc = cyc;
    @(posedge clk);
    #1 bus.job_valid = 1'b0;
  endtask

  task automatic wait_resps(input int target);
    int n;
    n = 0;
    while (n_resp < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("resp_count", 64'(n_resp), 64'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.comp_done = 1'b1;
    @(posedge clk);
    #1 bus.comp_done = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_job_ready",  bus.job_ready,  1'b1);
    chk("rst_comp_start", bus.comp_start, 1'b0);
    chk("rst_comp_stall", bus.comp_stall, 1'b0);
    chk("rst_resp_valid", bus.resp_valid, 1'b0);
    chk("rst_stray_cnt",  stray_cnt,      8'd0);
    chk("rst_comp_a_1",   bus.comp_a_1,   64'd0);
    chk("rst_comp_b",     bus.comp_b,     64'd0);
  endtask

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    rst            = 1'b1;
    bus.job_valid  = 1'b0;
    bus.job_a1     = '0;
    bus.job_a2     = '0;
    bus.job_b      = '0;
    bus.job_steps  = '0;
    bus.resp_ready = 1'b1;
    bus.comp_busy  = 1'b0;
    bus.comp_done  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;

    // 1: three steps, return after 5 cycles
    m_delay = 5;
    push_call(64'h1000, 64'h2000, 64'h3000);
    push_call(64'h3000, 64'h2000, 64'h1000);
    push_call(64'h1000, 64'h2000, 64'h3000);
    push_resp(16'd3, 1'b0, 64'h3000, 6);
    send_job(64'h1000, 64'h2000, 64'h3000, 16'd3);
    wait_resps(1);

    // 2: zero steps, no call, response one cycle after accept
    push_resp(16'd0, 1'b0, 64'hAAAA, 1);
    send_job(64'hAAAA, 64'hBBBB, 64'hCCCC, 16'd0);
    wait_resps(2);
    chk("zero_steps_calls", 64'(m_call_idx), 64'd0);

    // 3: component busy for 7 cycles on every call
    m_busy = 7;
    m_delay = 3;
    bus.comp_busy = 1'b1;
    push_calls(64'h40, 64'h80, 64'hC0, 2);
    push_resp(16'd2, 1'b0, 64'h40, 4);
    send_job(64'h40, 64'h80, 64'hC0, 16'd2);
    wait_resps(3);
    chk("busy_issue_len", 64'(issue_len), 64'd8);
    chk("busy_call_count", 64'(m_call_idx), 64'd2);
    m_busy = 0;
    bus.comp_busy = 1'b0;

    // 4: second call never returns -> watchdog after 16 wait cycles
    m_delay = 5;
    m_drop_from = 1;
    push_calls(64'h111, 64'h222, 64'h333, 2);
    push_resp(16'd1, 1'b1, 64'h333, 17);
    send_job(64'h111, 64'h222, 64'h333, 16'd4);
    wait_resps(4);
    m_drop_from = 1000;
    repeat (2) @(posedge clk);
    #1 pulse_done();
    @(negedge clk);
    chk("stray_after_timeout", stray_cnt, 8'd1);
    @(posedge clk);
    #1;

    // 5a: done lands exactly on the expiry cycle
    m_delay = 16;
    push_calls(64'h500, 64'h600, 64'h700, 1);
    push_resp(16'd1, 1'b0, 64'h700, 17);
    send_job(64'h500, 64'h600, 64'h700, 16'd1);
    wait_resps(5);

    // 5b: response back-pressured for 10 cycles, wide addresses
    m_delay = 2;
    bus.resp_ready = 1'b0;
    push_calls(64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 2);
    push_resp(16'd2, 1'b0, 64'hFEDC_BA98_7654_3210, 3);
    send_job(64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'h8000_0000_0000_0001, 16'd2);
    n = 0;
    while (!bus.resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("held_resp_seen", bus.resp_valid, 1'b1);
    repeat (10) @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    wait_resps(6);

    // 6: reset while waiting on the second call
    m_delay = 2;
    m_drop_from = 1;
    push_calls(64'h9000, 64'h9100, 64'h9200, 2);
    send_job(64'h9000, 64'h9100, 64'h9200, 16'd4);
    n = 0;
    while (m_call_idx < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_calls.delete();
    exp_resps.delete();
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 pulse_done();
    @(negedge clk);
    chk("stray_after_reset", stray_cnt, 8'd1);
    @(posedge clk);
    #1;
    m_drop_from = 1000;
    m_delay = 1;
    push_calls(64'hA0, 64'hB0, 64'hC0, 2);
    push_resp(16'd2, 1'b0, 64'hA0, 2);
    send_job(64'hA0, 64'hB0, 64'hC0, 16'd2);
    wait_resps(7);

    repeat (3) @(posedge clk);
    chk("calls_left", 64'(exp_calls.size()), 64'd0);
    chk("resps_left", 64'(exp_resps.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
